// File: rtl/adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_pipe
// Purpose  : Fully pipelined valid/ready binary adder tree over 2^LEVELS lanes
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_pipe #(
  parameter int WIDTH    = 9,
  parameter int N_INPUTS = 8,
  parameter int LEVELS   = 3,
  parameter int SIGNED   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH+LEVELS-1:0]   sum
);

  // Every level lives in one flat bus; level j holds 2^(LEVELS-j) values of WIDTH+j bits.
  function automatic int level_offset(input int lvl);
    int acc;
    acc = 0;
    for (int k = 0; k < lvl; k++) begin
      acc += (1 << (LEVELS - k)) * (WIDTH + k);
    end
    return acc;
  endfunction

  localparam int USED_LANES = 1 << LEVELS;
  localparam int TOTAL_BITS = level_offset(LEVELS + 1);
  localparam int OUT_OFF    = level_offset(LEVELS);

  logic [TOTAL_BITS-1:0] r_data;
  logic [TOTAL_BITS-1:0] w_next;
  logic [LEVELS:0]       r_valid;
  logic                  w_stall;

  assign w_stall   = r_valid[LEVELS] && !out_ready;
  assign in_ready  = !w_stall;
  assign out_valid = r_valid[LEVELS];
  assign sum       = r_data[OUT_OFF +: WIDTH+LEVELS];

  assign w_next[0 +: USED_LANES*WIDTH] = in_data[USED_LANES*WIDTH-1:0];

  for (genvar j = 1; j <= LEVELS; j++) begin : g_level
    localparam int NODES = 1 << (LEVELS - j);
    localparam int SW    = WIDTH + j;
    localparam int SRC   = level_offset(j - 1);
    localparam int DST   = level_offset(j);

    for (genvar i = 0; i < NODES; i++) begin : g_node
      logic [SW-2:0] w_a;
      logic [SW-2:0] w_b;
      logic          w_ext_a;
      logic          w_ext_b;

      assign w_a     = r_data[SRC + (2*i)*(SW-1)   +: SW-1];
      assign w_b     = r_data[SRC + (2*i+1)*(SW-1) +: SW-1];
      assign w_ext_a = (SIGNED != 0) ? w_a[SW-2] : 1'b0;
      assign w_ext_b = (SIGNED != 0) ? w_b[SW-2] : 1'b0;
      assign w_next[DST + i*SW +: SW] = {w_ext_a, w_a} + {w_ext_b, w_b};
    end
  end

  if (N_INPUTS > USED_LANES) begin : g_unused_lanes
    logic w_unused;
    assign w_unused = ^in_data[N_INPUTS*WIDTH-1:USED_LANES*WIDTH];
  end

  // Data registers load freely when not stalled; only the valid chain carries meaning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= '0;
    end else if (!w_stall) begin
      r_data  <= w_next;
      r_valid <= {r_valid[LEVELS-1:0], in_valid};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_pipe
// Purpose  : Scoreboard bench for adder_tree_pipe (default, LEVELS=2, SIGNED=1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_pipe;

  typedef struct {
    logic [63:0] val;
    int          cyc;
    int          stalls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic        r0, r1, r2;
  logic [71:0] d0 = '0, d1 = '0, d2 = '0;
  logic        ov0, ov1, ov2;
  logic        or0 = 1'b1, or1 = 1'b1, or2 = 1'b1;
  logic [11:0] s0;
  logic [10:0] s1;
  logic [11:0] s2;

  logic [63:0] p0, p1, p2;
  logic        a0, a1, a2;
  exp_t        q0[$], q1[$], q2[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cycle = 0;
  int          stalls0 = 0;
  logic        prev_stall0 = 1'b0;
  logic [11:0] prev_s0 = '0;
  logic        use_pat = 1'b0;
  int          pat_idx = 0;
  logic        ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  adder_tree_pipe u_dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .sum(s0)
  );

  adder_tree_pipe #(.LEVELS(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .sum(s1)
  );

  adder_tree_pipe #(.SIGNED(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .sum(s2)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [71:0] pack8(input int lv[8]);
    logic [71:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*9 +: 9] = 9'(lv[k]);
    return d;
  endfunction

  function automatic logic [63:0] ref_sum(input logic [71:0] data, input int nl,
                                          input bit sgn, input int ow);
    longint   acc;
    logic [8:0] lane;
    acc = 0;
    for (int k = 0; k < nl; k++) begin
      lane = data[k*9 +: 9];
      if (sgn) acc += longint'($signed(lane));
      else     acc += longint'({55'b0, lane});
    end
    return 64'(acc) & ((64'd1 << ow) - 64'd1);
  endfunction

  task automatic observe(input int id, input logic iv, input logic ir, input logic ov,
                         input logic orr, input logic [63:0] s, input logic [63:0] pend,
                         input int nstall, output logic accepted);
    exp_t e;
    int   qs;
    int   lat;
    lat = (id == 1) ? 3 : 4;
    qs  = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    check_val($sformatf("in_ready_%0d", id), 64'(ir), 64'(!(ov && !orr)));
    if (ov && qs == 0) begin
      check_val($sformatf("spurious_valid_%0d", id), 64'(ov), 64'd0);
    end else if (ov && orr) begin
      case (id)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check_val($sformatf("sum_%0d", id), s, e.val);
      check_val($sformatf("latency_%0d", id), 64'(cycle - e.cyc), 64'(lat + nstall - e.stalls));
    end
    accepted = iv && ir;
    if (accepted) begin
      case (id)
        0:       q0.push_back('{val: pend, cyc: cycle, stalls: nstall});
        1:       q1.push_back('{val: pend, cyc: cycle, stalls: nstall});
        default: q2.push_back('{val: pend, cyc: cycle, stalls: nstall});
      endcase
    end
  endtask

  task automatic step();
    if (use_pat) begin
      or0 = ready_pat[pat_idx % 7];
      pat_idx++;
    end
    @(negedge clk);
    observe(0, v0, r0, ov0, or0, {52'b0, s0}, p0, stalls0, a0);
    observe(1, v1, r1, ov1, or1, {53'b0, s1}, p1, 0, a1);
    observe(2, v2, r2, ov2, or2, {52'b0, s2}, p2, 0, a2);
    if (prev_stall0) begin
      check_val("stall_sum_stable", {52'b0, s0}, {52'b0, prev_s0});
      check_val("stall_valid_stable", 64'(ov0), 64'd1);
    end
    prev_stall0 = ov0 && !or0;
    prev_s0     = s0;
    if (prev_stall0) stalls0++;
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int id, input logic [71:0] data, input logic [63:0] expv,
                           input bit hold);
    int   guard;
    logic acc;
    guard = 0;
    case (id)
      0:       begin d0 = data; v0 = 1'b1; p0 = expv; end
      1:       begin d1 = data; v1 = 1'b1; p1 = expv; end
      default: begin d2 = data; v2 = 1'b1; p2 = expv; end
    endcase
    do begin
      step();
      guard++;
      acc = (id == 0) ? a0 : (id == 1) ? a1 : a2;
    end while (!acc && guard < 50);
    if (!acc) check_val($sformatf("accept_timeout_%0d", id), 64'(acc), 64'd1);
    if (!hold) begin
      case (id)
        0:       v0 = 1'b0;
        1:       v1 = 1'b0;
        default: v2 = 1'b0;
      endcase
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 60) begin
      step();
      guard++;
    end
    check_val("drain_left", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    repeat (3) step();
  endtask

  initial begin
    int          lv[8];
    logic [95:0] rnd;

    #2;
    check_val("reset_out_valid", 64'(ov0), 64'd0);
    check_val("reset_sum", {52'b0, s0}, 64'd0);
    check_val("reset_in_ready", 64'(r0), 64'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    step();

    lv = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_beat(0, pack8(lv), 64'd36, 0);
    drain();

    lv = '{511, 511, 511, 511, 511, 511, 511, 511};
    send_beat(0, pack8(lv), 64'hFF8, 0);
    lv = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_beat(0, pack8(lv), 64'd0, 0);
    drain();

    lv = '{100, 100, 100, 100, 500, 500, 500, 500};
    send_beat(1, pack8(lv), 64'd400, 0);
    lv = '{256, 256, 256, 256, 255, 255, 255, 255};
    send_beat(2, pack8(lv), 64'hFFC, 0);
    lv = '{256, 256, 256, 256, 256, 256, 256, 256};
    send_beat(2, pack8(lv), 64'h800, 0);
    drain();

    for (int k = 0; k < 6; k++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      send_beat(2, rnd[71:0], ref_sum(rnd[71:0], 8, 1'b1, 12), 1);
    end
    v2 = 1'b0;
    drain();

    use_pat = 1'b1;
    for (int k = 0; k < 10; k++) begin
      lv = '{0, 0, 0, 0, 0, 0, 0, 0};
      lv[k % 8] = k;
      send_beat(0, pack8(lv), 64'(k), k != 9);
    end
    drain();
    use_pat = 1'b0;
    or0 = 1'b1;

    for (int k = 0; k < 6; k++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      send_beat(0, rnd[71:0], ref_sum(rnd[71:0], 8, 1'b0, 12), 1);
      if (k == 2) begin
        v0 = 1'b0;
        step();
      end
    end
    v0 = 1'b0;
    drain();

    lv = '{10, 20, 30, 40, 50, 60, 70, 80};
    send_beat(0, pack8(lv), 64'd360, 1);
    lv = '{1, 1, 1, 1, 1, 1, 1, 1};
    send_beat(0, pack8(lv), 64'd8, 1);
    lv = '{7, 7, 7, 7, 7, 7, 7, 7};
    send_beat(0, pack8(lv), 64'd56, 0);
    #1 rst = 1'b1;
    #1;
    check_val("async_reset_out_valid", 64'(ov0), 64'd0);
    check_val("async_reset_sum", {52'b0, s0}, 64'd0);
    check_val("async_reset_in_ready", 64'(r0), 64'd1);
    q0.delete();
    q1.delete();
    q2.delete();
    prev_stall0 = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (8) step();
    lv = '{3, 3, 3, 3, 3, 3, 3, 3};
    send_beat(0, pack8(lv), 64'd24, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
